// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: command/LED bundle between a command source and led_mode_ctrl.
interface led_mode_ctrl_if #(
    parameter int LED_NUM  = 4,
    parameter int PWM_BITS = 8
);
    logic                led_en;
    logic [1:0]          led_mode;
    logic [LED_NUM-1:0]  led_data;
    logic [PWM_BITS-1:0] led_duty;
    logic [LED_NUM-1:0]  led;
    logic                cmd_ack;

    modport master (output led_en, led_mode, led_data, led_duty, input led, cmd_ack);
    modport slave  (input led_en, led_mode, led_data, led_duty, output led, cmd_ack);
endinterface

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: per-channel static/blink/PWM/off LED driver with registered outputs.
module led_mode_ctrl #(
    parameter int LED_NUM   = 4,
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 25_000_000,
    parameter bit DATA_INV  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    led_mode_ctrl_if.slave     bus
);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    // PWM period is 2^PWM_BITS-1 so an all-ones duty stays lit every cycle
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [1:0]          mode_r;
    logic [LED_NUM-1:0]  mask_r;
    logic [LED_NUM-1:0]  led_nx;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BW-1:0]       blink_cnt;
    logic                blink_ph;
    logic                pwm_on;

    assign pwm_on = pwm_cnt < duty_r;

    always_comb
        led_nx = mode_r == 2'b00 ? mask_r :
                 mode_r == 2'b01 ? mask_r & {LED_NUM{blink_ph}} :
                 mode_r == 2'b10 ? mask_r & {LED_NUM{pwm_on}} : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mode_r      <= 2'b11;
            mask_r      <= '0;
            duty_r      <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b1;
            bus.led     <= '0;
            bus.cmd_ack <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt == PWM_LAST ? '0 : pwm_cnt + 1'b1;
            bus.led     <= led_nx;
            bus.cmd_ack <= bus.led_en;
            if (bus.led_en) begin
                mode_r    <= bus.led_mode;
                mask_r    <= DATA_INV ? ~bus.led_data : bus.led_data;
                duty_r    <= bus.led_duty;
                blink_cnt <= '0;
                blink_ph  <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else
                blink_cnt <= blink_cnt + 1'b1;
        end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed vector table plus hand-written blink/PWM/hold/reset sequences.
module tb_led_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;

    led_mode_ctrl_if #(.LED_NUM(4), .PWM_BITS(4)) bus ();

    led_mode_ctrl #(.LED_NUM(4), .PWM_BITS(4), .BLINK_DIV(4), .DATA_INV(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] duty;
        logic [3:0] exp_led;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // one-cycle command pulse; returns just after the accepting edge
    task automatic issue(input logic [1:0] m, input logic [3:0] d, input logic [3:0] du);
        bus.led_en = 1'b1;
        bus.led_mode = m;
        bus.led_data = d;
        bus.led_duty = du;
        step();
        chk("ack_after_accept", 32'(bus.cmd_ack), 32'd1);
        bus.led_en = 1'b0;
    endtask

    initial begin
        int on;
        vecs[0] = '{"static_1010", 2'b00, 4'b1010, 4'd0,  4'b0101};
        vecs[1] = '{"static_0000", 2'b00, 4'b0000, 4'd0,  4'b1111};
        vecs[2] = '{"static_1111", 2'b00, 4'b1111, 4'd0,  4'b0000};
        vecs[3] = '{"off",         2'b11, 4'b0000, 4'd9,  4'b0000};
        vecs[4] = '{"static_0110", 2'b00, 4'b0110, 4'd0,  4'b1001};
        vecs[5] = '{"pwm_full",    2'b10, 4'b1110, 4'd15, 4'b0001};
        vecs[6] = '{"pwm_zero",    2'b10, 4'b0000, 4'd0,  4'b0000};

        // led_en ignored while in reset
        bus.led_en = 1'b1;
        bus.led_mode = 2'b00;
        bus.led_data = 4'b0000;
        bus.led_duty = 4'd0;
        repeat (3) step();
        chk("reset_led", 32'(bus.led), 32'd0);
        chk("reset_ack", 32'(bus.cmd_ack), 32'd0);
        bus.led_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("post_reset_off", 32'(bus.led), 32'd0);
        end

        foreach (vecs[i]) begin
            issue(vecs[i].mode, vecs[i].data, vecs[i].duty);
            step();
            chk({vecs[i].name, "_led"}, 32'(bus.led), 32'(vecs[i].exp_led));
            chk({vecs[i].name, "_ack_low"}, 32'(bus.cmd_ack), 32'd0);
        end

        // static hold
        issue(2'b00, 4'b1010, 4'd0);
        chk("static_latency", 32'(bus.led), 32'd0);
        on = 0;
        repeat (100) begin
            step();
            if (bus.led == 4'b0101) on++;
        end
        chk("static_hold_100", 32'(on), 32'd100);

        // blink: 4 lit, 4 off, repeating; re-issue in off phase restarts lit
        issue(2'b01, 4'b0000, 4'd0);
        for (int k = 0; k < 14; k++) begin
            step();
            chk("blink_phase", 32'(bus.led), ((k / 4) % 2 == 0) ? 32'hF : 32'h0);
        end
        issue(2'b01, 4'b0000, 4'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("blink_restart", 32'(bus.led), k < 4 ? 32'hF : 32'h0);
        end

        // pwm duty 5 on channel 0 only
        issue(2'b10, 4'b1110, 4'd5);
        step();
        on = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            on += int'(bus.led[0]);
            if (bus.led[3:1] != 3'b000) chk("pwm_upper_off", 32'(bus.led[3:1]), 32'd0);
        end
        chk("pwm_duty5_count", 32'(on), 32'd10);
        issue(2'b10, 4'b1110, 4'd0);
        step();
        on = 0;
        repeat (15) begin step(); on += int'(bus.led[0]); end
        chk("pwm_duty0_count", 32'(on), 32'd0);
        issue(2'b10, 4'b1110, 4'd15);
        step();
        on = 0;
        repeat (15) begin step(); on += int'(bus.led[0]); end
        chk("pwm_duty15_count", 32'(on), 32'd15);

        // led_en held 3 cycles, last data wins
        bus.led_en = 1'b1;
        bus.led_mode = 2'b00;
        bus.led_data = 4'b0000;
        step();
        chk("hold_ack1", 32'(bus.cmd_ack), 32'd1);
        bus.led_data = 4'b1111;
        step();
        chk("hold_ack2", 32'(bus.cmd_ack), 32'd1);
        bus.led_data = 4'b1100;
        step();
        chk("hold_ack3", 32'(bus.cmd_ack), 32'd1);
        bus.led_en = 1'b0;
        step();
        chk("hold_ack_end", 32'(bus.cmd_ack), 32'd0);
        chk("hold_last_wins", 32'(bus.led), 32'b0011);

        // async reset in blink lit phase with ack high
        bus.led_en = 1'b1;
        bus.led_mode = 2'b01;
        bus.led_data = 4'b0000;
        step();
        step();
        bus.led_en = 1'b0;
        chk("pre_reset_lit", 32'(bus.led), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", 32'(bus.led), 32'd0);
        chk("async_reset_ack", 32'(bus.cmd_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        on = 0;
        repeat (10) begin step(); if (bus.led != 4'b0000) on++; end
        chk("after_reset_dark", 32'(on), 32'd0);
        issue(2'b00, 4'b0000, 4'd0);
        step();
        chk("after_reset_cmd", 32'(bus.led), 32'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
